avalon_pio_out_blink: RTL and testbench
=======================================

AVALON_PIO_OUT_BLINK -- requirements
Module: avalon_pio_out_blink

Interface
REQ-001 SHALL have parameter: WIDTH, 4, output port width in bits (1..32).
REQ-002 SHALL have parameter: RESET_VALUE, 0, data register value after reset (WIDTH bits).
REQ-003 SHALL have parameter: PRESCALE_WIDTH, 24, blink prescaler width in bits (1..32).
REQ-004 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: address  input  3  Avalon-MM word address.
REQ-007 SHALL have port: chipselect  input  1  slave select.
REQ-008 SHALL have port: write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 SHALL have port: writedata  input  32  write data; bits above the register width ignored.
REQ-010 SHALL have port: readdata  output  32  read data, zero-extended.
REQ-011 SHALL have port: out_port  output  WIDTH  driven output pins.
REQ-012 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-013 SHALL define the write strobe as wr = chipselect & ~write_n.
REQ-014 SHALL provide a register map: 0 DATA (R/W), 1 BLINK_MASK (R/W), 2 OUTSET (W), 3 OUTCLEAR (W), 4 PRESCALE (R/W); addresses 5-7 read 0 and ignore writes.
REQ-015 SHALL return readdata combinationally (zero wait states, read latency 0) from the addressed register; OUTSET/OUTCLEAR read as 0.
REQ-016 SHALL on a DATA write load data <= writedata[WIDTH-1:0], visible on out_port the next cycle.
REQ-017 SHALL on an OUTSET write perform data <= data | writedata[WIDTH-1:0]; on an OUTCLEAR write, data <= data & ~writedata[WIDTH-1:0].
REQ-018 SHALL keep a prescaler counter cnt (PRESCALE_WIDTH bits) and a phase bit; each cycle: if cnt == prescale then cnt <= 0 and phase <= ~phase, else cnt <= cnt + 1.
REQ-019 SHALL with prescale == 0 toggle phase every cycle (square wave period 2 cycles); in general the period is 2*(prescale+1) cycles.
REQ-020 SHALL on a PRESCALE write load prescale, force cnt <= 0 and phase <= 1 in the same edge, overriding REQ-018.
REQ-021 SHALL drive out_port = data & ~(blink_mask & ~{WIDTH{phase}}), so masked bits follow data ANDed with phase and unmasked bits follow data.
REQ-022 SHALL leave cnt and phase unaffected by BLINK_MASK, DATA, OUTSET and OUTCLEAR writes.
REQ-023 SHALL wrap cnt to 0 only through REQ-018/REQ-020; no free-running overflow occurs because cnt never exceeds prescale except transiently after a smaller PRESCALE write, which REQ-020 prevents.
REQ-024 SHALL register out_port (no combinational path from writedata to out_port).

Reset
REQ-025 SHALL on reset set data <= RESET_VALUE, blink_mask <= 0, prescale <= 0, cnt <= 0, phase <= 1.
REQ-026 SHALL give reset priority over any simultaneous write.
REQ-027 SHALL present out_port = RESET_VALUE in the cycle after reset is sampled high; readdata reflects reset register values.

Configuration
REQ-028 SHALL compile the blink function only when macro PIO_OUT_BLINK_EN is defined.
REQ-029 SHALL without PIO_OUT_BLINK_EN omit blink_mask, prescale, cnt and phase, make addresses 1 and 4 read 0 and ignore writes, and drive out_port = data.

Verification
REQ-030 SHALL cover: WIDTH=4, reset 1 cycle -> out_port=0, readdata at addr 0 = 0x0.
REQ-031 SHALL cover: write DATA=0xA5 (WIDTH=4) -> next cycle out_port=0x5, read addr 0 = 0x00000005.
REQ-032 SHALL cover: DATA=0x3, write OUTSET=0x8 then OUTCLEAR=0x1 -> out_port 0xB then 0xA.
REQ-033 SHALL cover (blink): DATA=0xF, BLINK_MASK=0x1, PRESCALE=2 -> out_port bit0 high 3 cycles, low 3 cycles, repeating; bits 3:1 steady 1.
REQ-034 SHALL cover: PRESCALE=0 with mask 0xF, DATA=0xF -> out_port alternates 0xF/0x0 every cycle; rewrite PRESCALE mid-run -> phase restarts at 1 next cycle.
REQ-035 SHALL cover: reset asserted in the same cycle as a DATA=0x6 write -> out_port=RESET_VALUE, write lost; without PIO_OUT_BLINK_EN, read addr 4 = 0.

Source files
------------

// File: rtl/avalon_pio_out_blink_if.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pio_out_blink_if
// Purpose  : Avalon-MM slave bus bundle for the blinking output PIO.
// Revision : 1.0  initial release
// ============================================================================
interface avalon_pio_out_blink_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/avalon_pio_out_blink.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pio_out_blink
// Purpose  : Avalon-MM output PIO with set/clear strobes and an optional
//            per-bit blink mask driven by a programmable prescaler.
//            Blink logic is built only when PIO_OUT_BLINK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module avalon_pio_out_blink #(
    parameter int               WIDTH          = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter int               PRESCALE_WIDTH = 24
) (
    input  wire logic             clk,
    input  wire logic             reset,
    avalon_pio_out_blink_if.slave bus,
    output logic [WIDTH-1:0]      out_port
);
    localparam logic [2:0] c_ADDR_DATA     = 3'd0;
    localparam logic [2:0] c_ADDR_MASK     = 3'd1;
    localparam logic [2:0] c_ADDR_OUTSET   = 3'd2;
    localparam logic [2:0] c_ADDR_OUTCLR   = 3'd3;
    localparam logic [2:0] c_ADDR_PRESCALE = 3'd4;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic [31:0]      w_rd;
    logic             w_unused_wd;

    assign w_wr        = bus.chipselect & ~bus.write_n;
    assign w_wdata     = bus.writedata[WIDTH-1:0];
    assign w_unused_wd = ^bus.writedata;

    always_comb begin
        w_data_nxt = r_data;
        if (w_wr) begin
            case (bus.address)
                c_ADDR_DATA:   w_data_nxt = w_wdata;
                c_ADDR_OUTSET: w_data_nxt = r_data | w_wdata;
                c_ADDR_OUTCLR: w_data_nxt = r_data & ~w_wdata;
                default:       w_data_nxt = r_data;
            endcase
        end
    end

`ifdef PIO_OUT_BLINK_EN
    localparam logic [PRESCALE_WIDTH-1:0] c_CNT_ONE = PRESCALE_WIDTH'(1);

    logic [WIDTH-1:0]          r_mask;
    logic [WIDTH-1:0]          w_mask_nxt;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] w_prescale_nxt;
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [PRESCALE_WIDTH-1:0] w_cnt_nxt;
    logic                      r_phase;
    logic                      w_phase_nxt;

    always_comb begin
        w_mask_nxt     = r_mask;
        w_prescale_nxt = r_prescale;
        if (r_cnt == r_prescale) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = ~r_phase;
        end else begin
            w_cnt_nxt   = r_cnt + c_CNT_ONE;
            w_phase_nxt = r_phase;
        end
        if (w_wr && (bus.address == c_ADDR_MASK)) begin
            w_mask_nxt = w_wdata;
        end
        // A prescale write restarts the blink period in the high phase.
        if (w_wr && (bus.address == c_ADDR_PRESCALE)) begin
            w_prescale_nxt = bus.writedata[PRESCALE_WIDTH-1:0];
            w_cnt_nxt      = '0;
            w_phase_nxt    = 1'b1;
        end
        w_out_nxt = w_data_nxt & ~(w_mask_nxt & ~{WIDTH{w_phase_nxt}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask     <= '0;
            r_prescale <= '0;
            r_cnt      <= '0;
            r_phase    <= 1'b1;
        end else begin
            r_mask     <= w_mask_nxt;
            r_prescale <= w_prescale_nxt;
            r_cnt      <= w_cnt_nxt;
            r_phase    <= w_phase_nxt;
        end
    end

    always_comb begin
        w_rd = '0;
        case (bus.address)
            c_ADDR_DATA:     w_rd[WIDTH-1:0]          = r_data;
            c_ADDR_MASK:     w_rd[WIDTH-1:0]          = r_mask;
            c_ADDR_PRESCALE: w_rd[PRESCALE_WIDTH-1:0] = r_prescale;
            default:         w_rd                     = '0;
        endcase
    end
`else
    logic [PRESCALE_WIDTH-1:0] w_unused_pw;

    assign w_unused_pw = '0;
    assign w_out_nxt   = w_data_nxt;

    always_comb begin
        w_rd = '0;
        if (bus.address == c_ADDR_DATA) begin
            w_rd[WIDTH-1:0] = r_data;
        end
    end
`endif

    // The pin register is loaded with the next-state value so that the
    // pins change in the same cycle as the registers they are derived from.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= RESET_VALUE;
            r_out  <= RESET_VALUE;
        end else begin
            r_data <= w_data_nxt;
            r_out  <= w_out_nxt;
        end
    end

    assign bus.readdata = w_rd;
    assign out_port     = r_out;
endmodule
`default_nettype wire

// File: tb/tb_avalon_pio_out_blink.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_pio_out_blink
// Purpose  : Self-checking bench for avalon_pio_out_blink (vector table,
//            blink corner sequences, random traffic against a model).
// Revision : 1.0  initial release
// ============================================================================
module tb_avalon_pio_out_blink;
    localparam int W  = 4;
    localparam int PW = 24;
`ifdef PIO_OUT_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] out_port;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    avalon_pio_out_blink_if bus();

    avalon_pio_out_blink #(
        .WIDTH          (W),
        .RESET_VALUE    (4'h0),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port)
    );

    // Reference model: blink phase derived from elapsed cycles since restart.
    logic [W-1:0] m_data;
    logic [W-1:0] m_mask;
    longint       m_pre;
    longint       m_t;
    bit           m_valid = 1'b0;

    function automatic logic [W-1:0] m_out();
        bit ph;
        ph = ((m_t / (m_pre + 1)) % 2) == 0;
        if (!BLINK) return m_data;
        return m_data & ~(m_mask & ~{W{ph}});
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        if (a == 3'd0) r[W-1:0] = m_data;
        if (BLINK && a == 3'd1) r[W-1:0] = m_mask;
        if (BLINK && a == 3'd4) r = 32'(m_pre);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One bus cycle, entered and left at the falling edge.
    task automatic cycle(input logic rst, input logic cs, input logic wrn,
                         input logic [2:0] a, input logic [31:0] wd,
                         output logic [31:0] rd_seen, output logic [W-1:0] out_seen);
        reset          = rst;
        bus.chipselect = cs;
        bus.write_n    = wrn;
        bus.address    = a;
        bus.writedata  = wd;
        #1;
        rd_seen = bus.readdata;
        if (m_valid) chk("model_rd", bus.readdata, m_rd(a));
        @(posedge clk);
        if (rst) begin
            m_data  = 4'h0;
            m_mask  = '0;
            m_pre   = 0;
            m_t     = 0;
            m_valid = 1'b1;
        end else begin
            m_t++;
            if (cs && !wrn) begin
                case (a)
                    3'd0: m_data = wd[W-1:0];
                    3'd1: if (BLINK) m_mask = wd[W-1:0];
                    3'd2: m_data = m_data | wd[W-1:0];
                    3'd3: m_data = m_data & ~wd[W-1:0];
                    3'd4: if (BLINK) begin m_pre = longint'(wd[PW-1:0]); m_t = 0; end
                    default: ;
                endcase
            end
        end
        #1;
        out_seen = out_port;
        chk("model_out", {28'h0, out_port}, {28'h0, m_out()});
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd, output logic [W-1:0] o);
        logic [31:0] rd;
        cycle(1'b0, 1'b1, 1'b0, a, wd, rd, o);
    endtask

    task automatic rdc(input logic [2:0] a, output logic [31:0] rd, output logic [W-1:0] o);
        cycle(1'b0, 1'b1, 1'b1, a, 32'h0, rd, o);
    endtask

    typedef struct {
        logic         rst;
        logic         cs;
        logic         wrn;
        logic [2:0]   addr;
        logic [31:0]  wd;
        logic         chk_rd;
        logic [31:0]  exp_rd;
        logic [W-1:0] exp_out;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [31:0]  rd;
        logic [W-1:0] o;

        reset          = 1'b1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        @(negedge clk);

        //           rst   cs    wrn   addr  wd            chk   exp_rd   out
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 3'd0, 32'h0,        1'b0, 32'h0,   4'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 3'd0, 32'h0,        1'b1, 32'h0,   4'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'd0, 32'hA5,       1'b0, 32'h0,   4'h5};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 3'd0, 32'h0,        1'b1, 32'h5,   4'h5};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'd0, 32'hFFFF_FFF3,1'b0, 32'h0,   4'h3};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 3'd2, 32'h8,        1'b1, 32'h0,   4'hB};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 3'd3, 32'h1,        1'b1, 32'h0,   4'hA};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'd5, 32'hF,        1'b1, 32'h0,   4'hA};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h1,        1'b1, 32'hA,   4'hA};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 3'd0, 32'h1,        1'b1, 32'hA,   4'hA};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3'd0, 32'h6,        1'b0, 32'h0,   4'h0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 3'd0, 32'h0,        1'b1, 32'h0,   4'h0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 3'd4, 32'h0,        1'b1, 32'h0,   4'h0};

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].rst, vecs[i].cs, vecs[i].wrn, vecs[i].addr, vecs[i].wd, rd, o);
            if (vecs[i].chk_rd) chk($sformatf("tbl_rd[%0d]", i), rd, vecs[i].exp_rd);
            chk($sformatf("tbl_out[%0d]", i), {28'h0, o}, {28'h0, vecs[i].exp_out});
        end

`ifdef PIO_OUT_BLINK_EN
        wr(3'd0, 32'hF, o);
        wr(3'd1, 32'h1, o);
        wr(3'd4, 32'h2, o);
        chk("blink_start", {28'h0, o}, 32'hF);
        for (int k = 1; k < 12; k++) begin
            rdc(3'd4, rd, o);
            chk($sformatf("blink_k%0d", k), {28'h0, o}, (((k / 3) % 2) == 0) ? 32'hF : 32'hE);
        end
        chk("prescale_rd", rd, 32'h2);
        wr(3'd1, 32'hF, o);
        wr(3'd4, 32'h0, o);
        chk("fast_start", {28'h0, o}, 32'hF);
        for (int k = 1; k < 6; k++) begin
            rdc(3'd0, rd, o);
            chk($sformatf("fast_k%0d", k), {28'h0, o}, (k % 2 == 0) ? 32'hF : 32'h0);
        end
        wr(3'd4, 32'h0, o);
        chk("restart_phase", {28'h0, o}, 32'hF);
        rdc(3'd0, rd, o);
        chk("restart_next", {28'h0, o}, 32'h0);
`else
        wr(3'd0, 32'h9, o);
        wr(3'd1, 32'hF, o);
        wr(3'd4, 32'h2, o);
        rdc(3'd1, rd, o);
        chk("nomask_rd", rd, 32'h0);
        rdc(3'd4, rd, o);
        chk("noprescale_rd", rd, 32'h0);
        for (int k = 0; k < 4; k++) begin
            rdc(3'd0, rd, o);
            chk($sformatf("steady_k%0d", k), {28'h0, o}, 32'h9);
        end
`endif

        for (int i = 0; i < 400; i++) begin
            logic        r_rst;
            logic [2:0]  a;
            logic [31:0] wd;
            r_rst = ($urandom_range(0, 49) == 0);
            a     = 3'($urandom_range(0, 7));
            wd    = (a == 3'd4) ? 32'($urandom_range(0, 4)) : $urandom;
            cycle(r_rst, 1'($urandom), 1'($urandom), a, wd, rd, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
